// File: rtl/mandel_iter.sv
// Mandelbrot escape-time engine: iterates z <- z^2 + c from z = 0 for one point,
// one magnitude check per clock, and reports escape status and update count.
//
// state | meaning
// IDLE  | waiting for start
// ITER  | one |z|^2 check (and z update) per clock
// DONE  | one-cycle result strobe; start here chains straight into ITER
module mandel_iter #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 24,
   parameter int MAX_ITER = 255,
   localparam int ITER_W  = $clog2(MAX_ITER + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [WIDTH-1:0]  c_re,
   input  logic signed [WIDTH-1:0]  c_im,
   output logic                     busy,
   output logic                     done,
   output logic                     diverged,
   output logic [ITER_W-1:0]        iter_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int PW = 2 * WIDTH;
   // 4.0 with 2*FRAC fractional bits, sized to the magnitude sum
   localparam logic [PW:0] FOUR = {{(PW - 2*FRAC - 2){1'b0}}, 1'b1, {(2*FRAC + 2){1'b0}}};
   localparam logic [ITER_W-1:0] N_MAX = ITER_W'(MAX_ITER);

   state_t                   state;
   logic signed [WIDTH-1:0]  z_re;
   logic signed [WIDTH-1:0]  z_im;
   logic signed [WIDTH-1:0]  cq_re;
   logic signed [WIDTH-1:0]  cq_im;
   logic [ITER_W-1:0]        n;

   logic signed [PW-1:0]     zr_x;
   logic signed [PW-1:0]     zi_x;
   logic signed [PW-1:0]     rr;
   logic signed [PW-1:0]     ii;
   logic signed [PW-1:0]     ri;
   logic signed [PW-1:0]     diff;
   logic signed [PW:0]       mag;
   logic                     escape;
   logic signed [WIDTH-1:0]  z_re_next;
   logic signed [WIDTH-1:0]  z_im_next;

   // Sign-extend first so the products are full 2*WIDTH signed results.
   assign zr_x = {{WIDTH{z_re[WIDTH-1]}}, z_re};
   assign zi_x = {{WIDTH{z_im[WIDTH-1]}}, z_im};
   assign rr   = zr_x * zr_x;
   assign ii   = zi_x * zi_x;
   assign ri   = zr_x * zi_x;
   assign diff = rr - ii;
   assign mag  = {rr[PW-1], rr} + {ii[PW-1], ii};
   assign escape = $signed(mag) > $signed(FOUR);

   // Slicing at FRAC is the arithmetic shift kept to WIDTH bits; 2*ri shifts one bit less.
   assign z_re_next = diff[FRAC+WIDTH-1:FRAC] + cq_re;
   assign z_im_next = ri[FRAC+WIDTH-2:FRAC-1] + cq_im;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         diverged   <= 1'b0;
         iter_count <= '0;
         z_re       <= '0;
         z_im       <= '0;
         cq_re      <= '0;
         cq_im      <= '0;
         n          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= ITER;
                  busy       <= 1'b1;
                  cq_re      <= c_re;
                  cq_im      <= c_im;
                  z_re       <= '0;
                  z_im       <= '0;
                  n          <= '0;
                  diverged   <= 1'b0;
                  iter_count <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            ITER: begin
               if (escape) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  diverged   <= 1'b1;
                  iter_count <= n;
               end else if (n == N_MAX) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  diverged   <= 1'b0;
                  iter_count <= n;
               end else begin
                  z_re <= z_re_next;
                  z_im <= z_im_next;
                  n    <= n + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mandel_iter.sv
// Scoreboard bench for mandel_iter: expected results are queued at start and
// compared (status, count, latency) when done pulses.
module tb_mandel_iter;

   localparam int W  = 32;
   localparam int F  = 24;
   localparam int ONE  = 1 << F;
   localparam int NEG2 = -(2 << F);
   localparam int C25  = 41943040;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic signed [W-1:0] c_re;
   logic signed [W-1:0] c_im;
   logic busy;
   logic done;
   logic diverged;
   logic [3:0] iter_count;

   logic start_b;
   logic busy_b;
   logic done_b;
   logic diverged_b;
   logic [7:0] iter_count_b;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      string tag;
      bit    dv;
      int    cnt;
      int    start_cyc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mandel_iter #(.WIDTH(W), .FRAC(F), .MAX_ITER(15)) u_dut (
      .clk(clk), .rst(rst), .start(start), .c_re(c_re), .c_im(c_im),
      .busy(busy), .done(done), .diverged(diverged), .iter_count(iter_count)
   );

   mandel_iter #(.WIDTH(W), .FRAC(F), .MAX_ITER(255)) u_big (
      .clk(clk), .rst(rst), .start(start_b), .c_re(c_re), .c_im(c_im),
      .busy(busy_b), .done(done_b), .diverged(diverged_b), .iter_count(iter_count_b)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Independent 64-bit reference, wrapping z to 32 bits like the datapath width
   function automatic void model(input longint cr, input longint ci, input int maxi,
                                 output bit dv, output int cnt);
      longint zr = 0;
      longint zi = 0;
      longint rr, ii, ri;
      dv = 1'b0;
      cnt = maxi;
      for (int k = 0; k <= maxi; k++) begin
         rr = zr * zr;
         ii = zi * zi;
         if (rr + ii > (longint'(4) <<< (2 * F))) begin
            dv = 1'b1;
            cnt = k;
            return;
         end
         if (k == maxi) return;
         ri = zr * zi;
         zr = longint'(int'(((rr - ii) >>> F) + cr));
         zi = longint'(int'(((2 * ri) >>> F) + ci));
      end
   endfunction

   task automatic send(input int cr, input int ci, input bit dv, input int cnt, input string tag);
      exp_t e;
      start = 1'b1;
      c_re = cr;
      c_im = ci;
      e.tag = tag;
      e.dv = dv;
      e.cnt = cnt;
      e.start_cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 400);
      if (!done) chk({tag, "_timeout"}, 0, 1);
   endtask

   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_div"}, diverged, e.dv);
            chk({e.tag, "_cnt"}, iter_count, e.cnt);
            chk({e.tag, "_lat"}, cyc - e.start_cyc + 1, e.cnt + 2);
            chk({e.tag, "_busy"}, busy, 0);
         end
      end
   end

   initial begin
      bit dv;
      int cnt, cr, ci, k;
      rst = 1'b1;
      start = 1'b0;
      start_b = 1'b0;
      c_re = '0;
      c_im = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_div", diverged, 0);
      chk("rst_cnt", iter_count, 0);
      rst = 1'b0;
      @(negedge clk);

      send(0, 0, 0, 15, "zero");
      wait_done("zero");
      send(ONE, 0, 1, 3, "one");
      wait_done("one");
      send(NEG2, 0, 0, 15, "neg2");
      chk("b2b_busy", busy, 1);
      chk("accept_clr_div", diverged, 0);
      chk("accept_clr_cnt", iter_count, 0);
      wait_done("neg2");
      send(C25, 0, 1, 1, "c25");
      wait_done("c25");
      send(0, ONE, 0, 15, "imag");
      wait_done("imag");

      send(0, 0, 0, 15, "ignore");
      repeat (3) @(negedge clk);
      start = 1'b1;
      c_re = ONE;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore");

      for (int i = 0; i < 5; i++) begin
         cr = int'($urandom_range(0, 2 * C25)) - C25;
         ci = int'($urandom_range(0, 2 * C25)) - C25;
         model(cr, ci, 15, dv, cnt);
         send(cr, ci, dv, cnt, $sformatf("rnd%0d", i));
         wait_done($sformatf("rnd%0d", i));
      end
      @(negedge clk);

      send(0, 0, 0, 15, "rst_mid");
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_div", diverged, 0);
      chk("midrst_cnt", iter_count, 0);
      sb.delete();
      rst = 1'b0;
      @(negedge clk);
      send(ONE, 0, 1, 3, "post_rst");
      wait_done("post_rst");
      @(negedge clk);

      c_re = '0;
      c_im = '0;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      k = 1;
      while (!done_b && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("big_done_seen", done_b, 1);
      chk("big_div", diverged_b, 0);
      chk("big_cnt", iter_count_b, 255);
      chk("big_lat", k, 257);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
